cordic_req_sched: RTL and testbench

Round-robin scheduler that shares one folded CORDIC cosine accelerator between several requesters (custom-instruction ports, DMA engine). It accepts one single-precision operand at a time, issues a one-cycle `start` to the accelerator, waits its fixed latency, captures `y_ft`, and returns the result to the granted requester. It sits between the requester ports and the accelerator's `start`/`x_ft`/`y_ft` pins and drives the accelerator's `clk_en`.

---
 rtl/cordic_req_sched.sv | 135 +++++++++++++
 tb/tb_cordic_req_sched.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cordic_req_sched.sv
`default_nettype none
// ============================================================================
// Module      : cordic_req_sched
// Description : Round-robin scheduler sharing one folded CORDIC cosine
//               accelerator between N_REQ requesters. It handles one operand
//               at a time: accept, start pulse, fixed-latency wait, capture,
//               then a one-cycle response to the granted requester.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_req_sched #(
    parameter int N_REQ   = 4,
    parameter int ACC_LAT = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_en,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [32*N_REQ-1:0]  req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [31:0]          rsp_data,
    output logic                 acc_clk_en,
    output logic                 acc_start,
    output logic [31:0]          acc_x_ft,
    input  logic [31:0]          acc_y_ft,
    output logic                 busy,
    output logic [15:0]          done_count
);

    localparam int GW = (N_REQ > 2) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [7:0]       C_LAT_LOAD = 8'(ACC_LAT - 1);
    localparam logic [GW-1:0]    C_LAST_REQ = GW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] C_ONE      = N_REQ'(1);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [GW-1:0] r_rr_ptr;
    logic [GW-1:0] r_gnt;
    logic [7:0]    r_lat_cnt;
    logic [31:0]   r_op;
    logic [31:0]   r_res;
    logic [15:0]   r_done_count;
    logic [GW-1:0] w_gnt;
    logic          w_found;

    // Round-robin arbiter: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        int idx;
        w_gnt   = '0;
        w_found = 1'b0;
        idx     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(r_rr_ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!w_found && req_valid[idx]) begin
                w_found = 1'b1;
                w_gnt   = GW'(idx);
            end
        end
    end

    // State register; reset wins over clk_en, clk_en freezes everything else.
    always_ff @(posedge clk) begin
        if (reset)       r_state <= ST_IDLE;
        else if (clk_en) r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_found) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (r_lat_cnt == 8'd0) w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs; strobes are masked by clk_en so nothing fires on a frozen cycle.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        acc_start = 1'b0;
        rsp_data  = '0;
        if (clk_en && r_state == ST_IDLE && w_found) req_ready = C_ONE << w_gnt;
        if (clk_en && r_state == ST_ISSUE)           acc_start = 1'b1;
        if (clk_en && r_state == ST_RESP)            rsp_valid = C_ONE << r_gnt;
        if (r_state == ST_RESP)                      rsp_data  = r_res;
    end

    // Datapath: operand/result capture, latency counter, pointer and tally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr     <= '0;
            r_gnt        <= '0;
            r_lat_cnt    <= '0;
            r_op         <= '0;
            r_res        <= '0;
            r_done_count <= '0;
        end else if (clk_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gnt <= w_gnt;
                        r_op  <= req_data[{w_gnt, 5'd0} +: 32];
                    end
                end
                ST_ISSUE: r_lat_cnt <= C_LAT_LOAD;
                ST_WAIT: begin
                    if (r_lat_cnt == 8'd0) r_res <= acc_y_ft;
                    else                   r_lat_cnt <= r_lat_cnt - 8'd1;
                end
                ST_RESP: begin
                    r_done_count <= r_done_count + 16'd1;
                    r_rr_ptr     <= (r_gnt == C_LAST_REQ) ? '0 : r_gnt + GW'(1);
                end
                default: ;
            endcase
        end
    end

    assign acc_clk_en = clk_en;
    assign acc_x_ft   = r_op;
    assign busy       = (r_state != ST_IDLE);
    assign done_count = r_done_count;

endmodule
`default_nettype wire

// File: tb/tb_cordic_req_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_req_sched
// Description : Directed bench for cordic_req_sched with a stub accelerator
//               returning x+1, ACC_LAT cycles after the start pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_req_sched;

    localparam int N_REQ   = 4;
    localparam int ACC_LAT = 6;

    logic                clk = 1'b0;
    logic                reset;
    logic                clk_en;
    logic [N_REQ-1:0]    req_valid;
    logic [32*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    rsp_valid;
    logic [31:0]         rsp_data;
    logic                acc_clk_en;
    logic                acc_start;
    logic [31:0]         acc_x_ft;
    logic [31:0]         acc_y_ft;
    logic                busy;
    logic [15:0]         done_count;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_done = 0;

    cordic_req_sched #(.N_REQ(N_REQ), .ACC_LAT(ACC_LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .acc_clk_en (acc_clk_en),
        .acc_start  (acc_start),
        .acc_x_ft   (acc_x_ft),
        .acc_y_ft   (acc_y_ft),
        .busy       (busy),
        .done_count (done_count)
    );

    always #5 clk = ~clk;

    // Stub accelerator: garbage right after start, x+1 once the latency elapses.
    logic [7:0] s_cnt;
    always @(posedge clk) begin
        if (reset) begin
            s_cnt    <= 8'd0;
            acc_y_ft <= 32'd0;
        end else if (clk_en) begin
            if (acc_start) begin
                s_cnt    <= 8'(ACC_LAT - 1);
                acc_y_ft <= 32'hDEAD_BEEF;
            end else if (s_cnt == 8'd1) begin
                s_cnt    <= 8'd0;
                acc_y_ft <= acc_x_ft + 32'd1;
            end else if (s_cnt != 8'd0) begin
                s_cnt <= s_cnt - 8'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Run one transaction for requester g (its req_valid already raised, now cycle 0).
    // clk_en is held low for st_len cycles starting at cycle st_first.
    task automatic txn(input int g, input logic [31:0] op, input int st_first, input int st_len);
        int rsp_cyc;
        rsp_cyc = 2 + ACC_LAT + st_len;
        settle();
        chk("grant_ready", 32'(req_ready), 32'(1 << g));
        chk("idle_busy", 32'(busy), 32'd0);
        step();
        req_valid[g] = 1'b0;
        settle();
        chk("issue_start", 32'(acc_start), 32'd1);
        chk("issue_xft", acc_x_ft, op);
        chk("issue_busy", 32'(busy), 32'd1);
        for (int c = 2; c <= rsp_cyc; c++) begin
            step();
            clk_en = (c >= st_first && c < st_first + st_len) ? 1'b0 : 1'b1;
            settle();
            if (c < rsp_cyc) begin
                chk("wait_rsp_low", 32'(rsp_valid), 32'd0);
                chk("wait_start_low", 32'(acc_start), 32'd0);
            end else begin
                chk("rsp_valid", 32'(rsp_valid), 32'(1 << g));
                chk("rsp_data", rsp_data, op + 32'd1);
                chk("rsp_xft_stable", acc_x_ft, op);
            end
        end
        exp_done++;
        step();
        settle();
        chk("done_count", 32'(done_count), 32'(exp_done));
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_rsp_low", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        clk_en    = 1'b1;
        req_valid = '0;
        req_data  = '0;
        repeat (3) step();
        reset = 1'b0;
        settle();

        // Reset values.
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_start", 32'(acc_start), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_xft", acc_x_ft, 32'd0);
        chk("rst_done", 32'(done_count), 32'd0);
        chk("acc_clk_en_hi", 32'(acc_clk_en), 32'd1);

        // Single request from requester 2.
        step();
        req_data[2*32 +: 32] = 32'h3C23_D70A;
        req_valid            = 4'b0100;
        txn(2, 32'h3C23_D70A, 99, 0);

        // clk_en low in IDLE: no accept strobe, no state change.
        clk_en    = 1'b0;
        req_valid = 4'b0001;
        settle();
        chk("gated_ready", 32'(req_ready), 32'd0);
        chk("acc_clk_en_lo", 32'(acc_clk_en), 32'd0);
        step();
        settle();
        chk("gated_busy", 32'(busy), 32'd0);
        clk_en    = 1'b1;
        req_valid = 4'b0000;

        // Mid-transaction reset (with clk_en low) drops the operand.
        step();
        req_data[1*32 +: 32] = 32'h0000_1234;
        req_valid            = 4'b0010;
        settle();
        chk("rr_from_3_ready", 32'(req_ready), 32'b0010);
        step();
        req_valid = 4'b0000;
        step();
        step();
        step();
        reset  = 1'b1;
        clk_en = 1'b0;
        step();
        reset  = 1'b0;
        clk_en = 1'b1;
        settle();
        exp_done = 0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done_count), 32'd0);
        chk("midrst_xft", acc_x_ft, 32'd0);
        for (int c = 0; c < ACC_LAT + 4; c++) begin
            chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
            step();
        end

        // All four valid: rr_ptr cleared by reset, so order is 0,1,2,3.
        req_data  = {32'h40, 32'h30, 32'h20, 32'h10};
        req_valid = 4'b1111;
        txn(0, 32'h10, 99, 0);
        txn(1, 32'h20, 99, 0);
        txn(2, 32'h30, 99, 0);
        txn(3, 32'h40, 99, 0);

        // Fairness: after requester 3, both 0 and 3 valid -> 0 then 3.
        req_data  = {32'h0BAD_0003, 32'h0, 32'h0, 32'h0BAD_0000};
        req_valid = 4'b1001;
        txn(0, 32'h0BAD_0000, 99, 0);
        txn(3, 32'h0BAD_0003, 99, 0);

        // Three-cycle clk_en stall in WAIT pushes the response to cycle 11.
        req_data[2*32 +: 32] = 32'h7FC0_0000;
        req_valid            = 4'b0100;
        txn(2, 32'h7FC0_0000, 3, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
